// File: rtl/hilo_mdu.sv
// HI/LO multiply-divide unit: fixed-latency multiply, one-bit-per-cycle restoring divide,
// and direct HI/LO writes. Results only reach hi/lo on the final cycle of an operation.
module hilo_mdu #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_RSV6  = 3'b110,
    OP_RSV7  = 3'b111
  } op_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  // acc holds the multiplicand, or the dividend shifting into the quotient
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sgn_q, sgn_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;

  op_e              op_s;
  logic             take;
  logic             is_div;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;

  assign op_s = op_e'(op);
  assign take = start && !cancel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      sgn_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      acc_q     <= acc_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      sgn_q     <= sgn_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  // A zero divisor jumps straight to the last count so the divide lasts one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (take && (op_s == OP_MULT || op_s == OP_MULTU)) begin
          state_d = MUL;
          cnt_d   = '0;
        end else if (take && (op_s == OP_DIV || op_s == OP_DIVU)) begin
          state_d = DIV;
          cnt_d   = (b == '0) ? DIV_LAST : '0;
        end
      end
      MUL: begin
        if (cancel || cnt_q == MUL_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DIV: begin
        if (cancel || cnt_q == DIV_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    acc_d     = acc_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    sgn_d     = sgn_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    is_div    = (op_s == OP_DIV);

    ext_a   = sgn_q ? {{WIDTH{acc_q[WIDTH-1]}}, acc_q} : {{WIDTH{1'b0}}, acc_q};
    ext_b   = sgn_q ? {{WIDTH{dvs_q[WIDTH-1]}}, dvs_q} : {{WIDTH{1'b0}}, dvs_q};
    prod    = ext_a * ext_b;
    shifted = {rem_q, acc_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};

    unique case (state_q)
      IDLE: begin
        if (take) begin
          unique case (op_s)
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            OP_MULT, OP_MULTU: begin
              acc_d = a;
              dvs_d = b;
              sgn_d = (op_s == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              neg_quo_d = is_div && (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_d = is_div && a[WIDTH-1];
              acc_d     = (is_div && a[WIDTH-1]) ? -a : a;
              dvs_d     = (is_div && b[WIDTH-1]) ? -b : b;
              rem_d     = '0;
              div0_d    = (b == '0);
            end
            default: ;
          endcase
        end
      end
      MUL: begin
        if (!cancel && cnt_q == MUL_LAST) begin
          hi_d   = prod[2*WIDTH-1:WIDTH];
          lo_d   = prod[WIDTH-1:0];
          done_d = 1'b1;
        end
      end
      DIV: begin
        if (!cancel) begin
          if (cnt_q == DIV_LAST) begin
            done_d = 1'b1;
            if (!div0_q) begin
              lo_d = neg_quo_q ? -acc_q : acc_q;
              hi_d = neg_rem_q ? -rem_q : rem_q;
            end
          end else if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            acc_d = {acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted[WIDTH-1:0];
            acc_d = {acc_q[WIDTH-2:0], 1'b0};
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Directed self-checking bench for hilo_mdu at WIDTH=32, MUL_LAT=2.
module tb_hilo_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  int nbusy, ndone, done_at;

  always #5 clk = ~clk;

  hilo_mdu #(.WIDTH(32), .MUL_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives one start and observes a fixed 40-cycle window.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int nb, output int nd, output int dat);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 0; nd = 0; dat = -1;
    for (int i = 0; i < 40; i++) begin
      if (busy) nb++;
      if (done) begin
        nd++;
        if (dat < 0) dat = i;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(3'b100, 32'hDEADBEEF, 32'h0, nbusy, ndone, done_at);
    check("mthi_hi", hi, 32'hDEADBEEF);
    check("mthi_busy", nbusy, 0);
    check("mthi_done", ndone, 0);
    run_op(3'b101, 32'h00000001, 32'h0, nbusy, ndone, done_at);
    check("mtlo_lo", lo, 32'h00000001);
    check("mtlo_hi", hi, 32'hDEADBEEF);
    check("mtlo_busy", nbusy, 0);
    check("mtlo_done", ndone, 0);

    run_op(3'b000, 32'hFFFFFFFD, 32'd7, nbusy, ndone, done_at);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFEB);
    check("mult_busy", nbusy, 2);
    check("mult_done", ndone, 1);
    check("mult_done_at", done_at, 2);

    run_op(3'b001, 32'hFFFFFFFD, 32'd7, nbusy, ndone, done_at);
    check("multu_hi", hi, 32'h00000006);
    check("multu_lo", lo, 32'hFFFFFFEB);
    check("multu_busy", nbusy, 2);
    check("multu_done", ndone, 1);

    run_op(3'b010, 32'hFFFFFFF9, 32'd2, nbusy, ndone, done_at);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);
    check("div_busy", nbusy, 33);
    check("div_done", ndone, 1);
    check("div_done_at", done_at, 33);

    run_op(3'b011, 32'd100, 32'd7, nbusy, ndone, done_at);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    check("divu_busy", nbusy, 33);

    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, nbusy, ndone, done_at);
    check("divmin_lo", lo, 32'h80000000);
    check("divmin_hi", hi, 32'h0);
    check("divmin_busy", nbusy, 33);

    run_op(3'b100, 32'h11, 32'h0, nbusy, ndone, done_at);
    run_op(3'b101, 32'h22, 32'h0, nbusy, ndone, done_at);
    run_op(3'b011, 32'd5, 32'd0, nbusy, ndone, done_at);
    check("div0_busy", nbusy, 1);
    check("div0_done", ndone, 1);
    check("div0_done_at", done_at, 1);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    // Cancel on the 10th busy cycle of DIVU 100/7.
    op = 3'b011; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("cancel_busy_before", busy, 1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_done", done, 0);
    check("cancel_hi", hi, 32'h11);
    check("cancel_lo", lo, 32'h22);
    run_op(3'b001, 32'h00010000, 32'h00010000, nbusy, ndone, done_at);
    check("after_cancel_hi", hi, 32'h1);
    check("after_cancel_lo", lo, 32'h0);
    check("after_cancel_busy", nbusy, 2);
    check("after_cancel_done", ndone, 1);

    // Cancel together with start in IDLE drops the MTHI.
    op = 3'b100; a = 32'hAAAA; start = 1'b1; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    check("cancel_start_hi", hi, 32'h1);
    check("cancel_start_busy", busy, 0);

    run_op(3'b110, 32'h1234, 32'd5, nbusy, ndone, done_at);
    check("rsv_busy", nbusy, 0);
    check("rsv_done", ndone, 0);
    check("rsv_hi", hi, 32'h1);
    check("rsv_lo", lo, 32'h0);

    // A start while busy is ignored.
    op = 3'b000; a = 32'd3; b = 32'd5; start = 1'b1;
    @(negedge clk);
    op = 3'b100; a = 32'h5555;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("ign_done", done, 1);
    check("ign_busy", busy, 0);
    check("ign_hi", hi, 32'h0);
    check("ign_lo", lo, 32'd15);

    // Asynchronous reset between edges in the middle of a multiply.
    op = 3'b001; a = 32'h12345; b = 32'h1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("arst_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_after_hi", hi, 0);
    check("arst_after_lo", lo, 0);
    check("arst_after_busy", busy, 0);
    check("arst_after_done", done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hilo_mdu.md
HILO_MDU -- requirements
Module: hilo_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO register width.
REQ-002 SHALL have parameter MUL_LAT, default 2, range 1..8, giving the multiply latency in cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: the operation request, sampled at the rising edge.
REQ-006 SHALL have port op, input, 3 bits, with these encodings:
- 000 MULT
- 001 MULTU
- 010 DIV
- 011 DIVU
- 100 MTHI
- 101 MTLO
- 110/111 reserved, treated as no-op.
REQ-007 SHALL have port a, input, WIDTH bits: operand A (dividend or multiplicand; the write data for MTHI/MTLO).
REQ-008 SHALL have port b, input, WIDTH bits: operand B (divisor or multiplier).
REQ-009 SHALL have port cancel, input, 1 bit: aborts the operation in flight (pipeline flush).
REQ-010 SHALL have port busy, output, 1 bit: high while a multiply or divide is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse on the first cycle the new multiply/divide result is visible on hi/lo.
REQ-012 SHALL have port hi, output, WIDTH bits: the registered HI value.
REQ-013 SHALL have port lo, output, WIDTH bits: the registered LO value.

Function
REQ-014 SHALL implement the states IDLE, MUL and DIV; busy = (state != IDLE).
REQ-015 SHALL accept start only in IDLE; start while busy is ignored, with no queuing.
REQ-016 SHALL write a to HI at the sampling edge on MTHI (MTLO: a to LO); the other register is unchanged, busy stays 0 and done is not asserted.
REQ-017 SHALL, on MULT/MULTU, capture a and b at the start edge, enter MUL and hold it for exactly MUL_LAT cycles.
REQ-018 SHALL compute the full 2*WIDTH-bit product, signed for MULT and unsigned for MULTU; HI = upper WIDTH bits, LO = lower WIDTH bits.
REQ-019 SHALL write HI/LO at the MUL_LAT-th edge after the start edge, return to IDLE on that same edge, and drive done=1 for the following cycle.
REQ-020 SHALL, on DIV/DIVU with b != 0, capture the operands and run a radix-2 restoring divide of one quotient bit per cycle: WIDTH iteration cycles plus 1 sign-fixup cycle, so busy is high for WIDTH+1 cycles.
REQ-021 SHALL give the divide results as LO = quotient and HI = remainder.
REQ-022 SHALL, for DIV, divide the magnitudes; the quotient is negated when the operand signs differ and the remainder takes the dividend's sign; DIVU is pure unsigned.
REQ-023 SHALL return, for DIV with most-negative / -1, quotient = most-negative value (two's-complement wrap) and remainder 0, with no trap.
REQ-024 SHALL, on a divide with b == 0, leave HI/LO unchanged, spend exactly 1 busy cycle, and then pulse done.
REQ-025 SHALL, on cancel while busy, return to IDLE at the next edge with no HI/LO write and no done pulse; a new start is accepted on the cycle after.
REQ-026 SHALL give cancel priority over start when both are high in IDLE: start is dropped and no MTHI/MTLO write occurs.
REQ-027 SHALL treat cancel on the done cycle as having no effect: the result has already been committed.
REQ-028 SHALL treat a reserved op with start as a no-op: the state stays IDLE and nothing is written.
REQ-029 SHALL keep hi/lo stable at all times except at write edges; no intermediate divide or multiply values appear on hi/lo.

Reset
REQ-030 SHALL, when rst_n=0, immediately and asynchronously force hi=0, lo=0, busy=0, done=0, state=IDLE and clear the iteration counter, regardless of the clock.
REQ-031 SHALL discard any in-flight operation on reset (including mid-operation) without writing it; operation resumes on the first edge after rst_n deasserts.

Verification (WIDTH=32, MUL_LAT=2)
REQ-032 SHALL cover MTHI a=0xDEADBEEF, then MTLO a=0x00000001: hi=0xDEADBEEF, lo=0x00000001, busy never high, done never pulsed.
REQ-033 SHALL cover multiply with a=0xFFFFFFFD, b=7:
- MULT: hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU: hi=0x00000006, lo=0xFFFFFFEB.
- Both: busy high 2 cycles, done 1 cycle.
REQ-034 SHALL cover divide:
- DIV a=-7, b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=7: lo=14, hi=2.
- DIV a=0x80000000, b=-1: lo=0x80000000, hi=0.
- All: busy high 33 cycles.
REQ-035 SHALL cover DIVU with b=0 and preloaded hi=0x11, lo=0x22: busy high 1 cycle, then done; hi/lo unchanged.
REQ-036 SHALL cover cancel asserted on the 10th cycle of DIVU 100/7: busy low next cycle, hi/lo unchanged, no done; a MULTU started on the following cycle completes normally.
REQ-037 SHALL cover rst_n pulled low between clock edges mid-MULT: hi=lo=0 and busy=0 before the next edge, with no result written after release; also a start while busy is ignored and the current result is unaffected.
